// File: rtl/shifter_pkg.sv
// Shared types and constants for the one-hot pass-transistor shifter front-end.
package shifter_pkg;
   localparam int SH_WIDTH = 8;
   localparam int SH_AMT_W = 3;

   typedef enum logic [1:0] {IDLE, DRIVE, HOLD} seq_state_t;

   function automatic logic [SH_WIDTH-1:0] onehot8(input logic [SH_AMT_W-1:0] amt);
      logic [SH_WIDTH-1:0] v;
      v = '0;
      v[amt] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/onehot_decoder.sv
// Combinational 3-to-8 one-hot decoder; all-zero output while en is low.
module onehot_decoder
   import shifter_pkg::*;
(
   input  logic                en,
   input  logic [SH_AMT_W-1:0] amt,
   output logic [SH_WIDTH-1:0] n
);
   assign n = en ? onehot8(amt) : '0;
endmodule

// File: rtl/shift_amount_sequencer.sv
// Request front-end for the one-hot-select shifter: drives D/N for SETTLE cycles,
// captures W, and returns the result over valid/ready.
module shift_amount_sequencer
   import shifter_pkg::*;
#(
   parameter int SETTLE = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SH_WIDTH-1:0] in_data,
   input  logic [SH_AMT_W-1:0] in_amt,
   output logic [SH_WIDTH-1:0] sh_d,
   output logic [SH_WIDTH-1:0] sh_n,
   input  logic [SH_WIDTH-1:0] sh_w,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [SH_WIDTH-1:0] out_data,
   output logic                busy
);
   seq_state_t          state, state_nxt;
   logic [3:0]          cnt;
   logic [SH_AMT_W-1:0] amt_q;
   logic                accept, capture, consume;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = DRIVE;
         end
         DRIVE: begin
            if (cnt == 4'd0) state_nxt = HOLD;
         end
         HOLD: begin
            in_ready = out_ready;
            if (out_ready) state_nxt = in_valid ? DRIVE : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign accept  = in_valid && in_ready;
   assign capture = (state == DRIVE) && (cnt == 4'd0);
   assign consume = (state == HOLD) && out_ready;
   assign busy    = (state == DRIVE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_d      <= '0;
         amt_q     <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            sh_d  <= in_data;
            amt_q <= in_amt;
            cnt   <= 4'(SETTLE - 1);
         end else if ((state == DRIVE) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (capture) begin
            out_data  <= sh_w;
            out_valid <= 1'b1;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Select is decoded from state so reset forces N to zero without waiting for an edge.
   onehot_decoder u_dec (
      .en  (busy),
      .amt (amt_q),
      .n   (sh_n)
   );
endmodule

// File: tb/tb_shift_amount_sequencer.sv
// Bench: two sequencers (SETTLE=1 and SETTLE=4) with behavioural shifters, checked every cycle
// against a transaction-level model plus literal expectations.
module tb_shift_amount_sequencer;
   localparam int ST[2] = '{1, 4};

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid[2], out_ready[2], in_ready[2], out_valid[2], busy[2];
   logic [7:0] in_data[2], sh_d[2], sh_n[2], sh_w[2], out_data[2];
   logic [2:0] in_amt[2];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int dut_res[2];

   // model state
   int         m_drive[2];
   logic       m_ovld[2];
   logic [7:0] m_odat[2], m_d[2], m_n[2], m_res[2];
   logic       acc_evt[2];

   always #5 clk = ~clk;

   shift_amount_sequencer #(.SETTLE(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data[0]), .in_amt(in_amt[0]), .sh_d(sh_d[0]), .sh_n(sh_n[0]),
      .sh_w(sh_w[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
      .out_data(out_data[0]), .busy(busy[0])
   );

   shift_amount_sequencer #(.SETTLE(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data[1]), .in_amt(in_amt[1]), .sh_d(sh_d[1]), .sh_n(sh_n[1]),
      .sh_w(sh_w[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
      .out_data(out_data[1]), .busy(busy[1])
   );

   // Behavioural shifter: W floats (modelled as junk) unless one select conducts.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         sh_w[k] = 8'hEE;
         for (int i = 0; i < 8; i++)
            if (sh_n[k][i]) sh_w[k] = sh_d[k] << i;
      end
   end

   task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d] at cycle %0d: got %0h want %0h", nm, k, cyc, act, exp);
      end
   endtask

   // Transaction-level reference: a request occupies the shifter for SETTLE cycles,
   // then its arithmetic result sits in the output slot until consumed.
   initial begin
      for (int k = 0; k < 2; k++) begin
         m_drive[k] = 0; m_ovld[k] = 1'b0; m_odat[k] = '0; m_d[k] = '0;
         m_n[k] = '0; m_res[k] = '0; acc_evt[k] = 1'b0; dut_res[k] = 0;
      end
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            for (int k = 0; k < 2; k++) begin
               m_drive[k] = 0; m_ovld[k] = 1'b0; m_odat[k] = '0; m_d[k] = '0;
               m_n[k] = '0; acc_evt[k] = 1'b0;
            end
         end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
               acc_evt[k] = in_valid[k] && (m_drive[k] == 0) && (!m_ovld[k] || out_ready[k]);
               if (m_drive[k] > 0) begin
                  m_drive[k]--;
                  if (m_drive[k] == 0) begin
                     m_ovld[k] = 1'b1;
                     m_odat[k] = m_res[k];
                  end
               end else begin
                  if (m_ovld[k] && out_ready[k]) m_ovld[k] = 1'b0;
                  if (acc_evt[k]) begin
                     m_drive[k] = ST[k];
                     m_d[k]     = in_data[k];
                     m_n[k]     = 8'd1 << in_amt[k];
                     m_res[k]   = 8'((16'(in_data[k]) << in_amt[k]) & 16'h00FF);
                  end
               end
            end
         end
      end
   end

   // Per-cycle compare against the model.
   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("sh_n", k, sh_n[k], (m_drive[k] > 0) ? m_n[k] : 8'h00);
            chk("sh_d", k, sh_d[k], m_d[k]);
            chk("busy", k, 8'(busy[k]), 8'(m_drive[k] > 0));
            chk("out_valid", k, 8'(out_valid[k]), 8'(m_ovld[k]));
            chk("out_data", k, out_data[k], m_odat[k]);
            chk("in_ready", k, 8'(in_ready[k]),
                8'((m_drive[k] == 0) && (!m_ovld[k] || out_ready[k])));
            chk("sh_n_onehot0", k, 8'($onehot0(sh_n[k])), 8'd1);
            chk("sh_n_outside_drive", k, 8'((sh_n[k] != 8'h00) && !busy[k]), 8'd0);
            if (out_valid[k] && out_ready[k]) dut_res[k]++;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Presents a request and returns 2 time units after the edge that accepted it.
   task automatic send(input int k, input logic [7:0] d, input logic [2:0] a);
      in_valid[k] = 1'b1; in_data[k] = d; in_amt[k] = a;
      for (int t = 0; t < 100; t++) begin
         @(posedge clk);
         #1;
         if (acc_evt[k]) begin
            #1;
            in_valid[k] = 1'b0;
            return;
         end
      end
      n_cmp++; n_bad++;
      $display("FAIL send_timeout[%0d]: no accept within 100 cycles, want accept", k);
      #1;
      in_valid[k] = 1'b0;
   endtask

   int n_busy, n_sel, first_acc, span, res_before;
   logic [7:0] seen;

   initial begin
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0; in_amt[k] = '0;
      end
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         chk("rst_in_ready", k, 8'(in_ready[k]), 8'd1);
         chk("rst_sh_n", k, sh_n[k], 8'h00);
         chk("rst_out_data", k, out_data[k], 8'h00);
      end

      // SETTLE=1 pair of requests
      out_ready[0] = 1'b1;
      send(0, 8'hB5, 3'd3);
      chk("b5_sh_n", 0, sh_n[0], 8'h08);
      step(1);
      chk("b5_valid", 0, 8'(out_valid[0]), 8'd1);
      chk("b5_data", 0, out_data[0], 8'hA8);
      chk("b5_sh_n_off", 0, sh_n[0], 8'h00);
      send(0, 8'h01, 3'd7);
      step(1);
      chk("x01_data", 0, out_data[0], 8'h80);
      step(2);

      // SETTLE=4, amount 0
      out_ready[1] = 1'b1;
      send(1, 8'h5A, 3'd0);
      n_busy = 0; n_sel = 0; seen = 8'h00;
      for (int t = 0; t < 10; t++) begin
         if (busy[1]) n_busy++;
         if (sh_n[1] == 8'h01) n_sel++;
         if (out_valid[1]) seen = out_data[1];
         step(1);
      end
      chk("s4_busy_cycles", 1, 8'(n_busy), 8'd4);
      chk("s4_sel_cycles", 1, 8'(n_sel), 8'd4);
      chk("s4_data", 1, seen, 8'h5A);

      // back-to-back, SETTLE=1
      res_before = dut_res[0];
      first_acc = 0;
      for (int i = 0; i < 8; i++) begin
         send(0, 8'($urandom), 3'(i));
         if (i == 0) first_acc = cyc;
         in_valid[0] = 1'b1;
      end
      in_valid[0] = 1'b0;
      span = cyc - first_acc;
      step(3);
      chk("b2b_span", 0, 8'(span), 8'd14);
      chk("b2b_results", 0, 8'(dut_res[0] - res_before), 8'd8);

      // backpressure
      out_ready[0] = 1'b0;
      send(0, 8'hC3, 3'd2);
      step(1);
      in_valid[0] = 1'b1; in_data[0] = 8'h3C; in_amt[0] = 3'd1;
      for (int t = 0; t < 5; t++) begin
         chk("bp_data", 0, out_data[0], 8'h0C);
         chk("bp_in_ready", 0, 8'(in_ready[0]), 8'd0);
         chk("bp_sh_n", 0, sh_n[0], 8'h00);
         step(1);
      end
      out_ready[0] = 1'b1;
      step(1);
      in_valid[0] = 1'b0;
      chk("bp_accept_sh_n", 0, sh_n[0], 8'h02);
      chk("bp_consumed", 0, 8'(out_valid[0]), 8'd0);
      step(1);
      chk("bp_new_data", 0, out_data[0], 8'h78);
      step(2);

      // reset in the middle of a drive window
      send(1, 8'hFF, 3'd1);
      step(1);
      rst = 1'b1;
      #1;
      chk("mid_rst_sh_n", 1, sh_n[1], 8'h00);
      chk("mid_rst_in_ready", 1, 8'(in_ready[1]), 8'd1);
      chk("mid_rst_busy", 1, 8'(busy[1]), 8'd0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      step(5);
      chk("post_rst_out_data", 1, out_data[1], 8'h00);
      chk("post_rst_valid", 1, 8'(out_valid[1]), 8'd0);

      // randomized traffic on both instances
      for (int t = 0; t < 600; t++) begin
         for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'($urandom_range(0, 1));
            in_data[k]   = 8'($urandom);
            in_amt[k]    = 3'($urandom_range(0, 7));
            out_ready[k] = ($urandom_range(0, 3) != 0);
         end
         step(1);
      end
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0; out_ready[k] = 1'b1;
      end
      step(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
